ctl_seq: RTL

Multi-cycle control sequencer that sits directly upstream of the yIF/yID/yEX/yDM/yWB datapath. It replaces hand-driven control in benches.
- Owns the PC.
- Decodes the fetched instruction into RegWrite/ALUSrc/op/MemRead/MemWrite/Mem2Reg.
- Steps each instruction through a fixed 4-state cycle.
- Computes the next PC for branch and jump.
- Counts retired instructions and halts at a limit or on an illegal opcode.

---
 rtl/ctl_pkg.sv | 41 ++++
 rtl/ctl_decode.sv | 66 ++++++
 rtl/ctl_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ctl_pkg.sv
// Shared constants and types for the ctl_seq control sequencer and its decoder.
package ctl_pkg;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LW  = 7'h03;
    localparam logic [6:0] OP_SW  = 7'h23;
    localparam logic [6:0] OP_BEQ = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6f;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // isBranch/isJump are not datapath controls; they steer the next-PC choice in WRITE.
    typedef struct packed {
        logic       regWrite;
        logic       aluSrc;
        logic [2:0] aluOp;
        logic       memRead;
        logic       memWrite;
        logic       mem2reg;
        logic       isBranch;
        logic       isJump;
    } ctl_word_t;

endpackage

// File: rtl/ctl_decode.sv
// Combinational instruction decoder: maps opcode/funct3 onto a control word,
// flagging anything outside the supported subset as illegal.
module ctl_decode
    import ctl_pkg::*;
(
    input  logic [31:0] ins,
    output ctl_word_t   ctlWord,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unusedBits;

    assign opcode     = ins[6:0];
    assign funct3     = ins[14:12];
    assign unusedBits = ^{ins[31:15], ins[11:7]};

    always_comb begin
        ctlWord = '0;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                ctlWord.regWrite = 1'b1;
                case (funct3)
                    F3_ADD:  ctlWord.aluOp = ALU_ADD;
                    F3_OR:   ctlWord.aluOp = ALU_OR;
                    F3_AND:  ctlWord.aluOp = ALU_AND;
                    default: begin
                        ctlWord = '0;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_I: begin
                ctlWord.regWrite = 1'b1;
                ctlWord.aluSrc   = 1'b1;
                ctlWord.aluOp    = ALU_ADD;
            end
            OP_LW: begin
                ctlWord.regWrite = 1'b1;
                ctlWord.aluSrc   = 1'b1;
                ctlWord.aluOp    = ALU_ADD;
                ctlWord.memRead  = 1'b1;
                ctlWord.mem2reg  = 1'b1;
            end
            OP_SW: begin
                ctlWord.aluSrc   = 1'b1;
                ctlWord.aluOp    = ALU_ADD;
                ctlWord.memWrite = 1'b1;
            end
            OP_BEQ: begin
                ctlWord.aluOp    = ALU_SUB;
                ctlWord.isBranch = 1'b1;
            end
            OP_JAL: begin
                ctlWord.regWrite = 1'b1;
                ctlWord.aluSrc   = 1'b1;
                ctlWord.aluOp    = ALU_ADD;
                ctlWord.isJump   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctl_seq.sv
// Multi-cycle control sequencer: owns the PC, steps each instruction through
// FETCH/DECODE/EXEC/WRITE, counts retirements and halts on limit or illegal opcode.
module ctl_seq
    import ctl_pkg::*;
#(
    parameter int MAX_INS = 43,
    parameter int PC_W    = 32
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PC_W-1:0] entry_pc,
    input  logic [31:0]     ins,
    input  logic [PC_W-1:0] pcp4,
    input  logic            zero,
    input  logic [PC_W-1:0] branch,
    input  logic [PC_W-1:0] jtarget,
    output logic [PC_W-1:0] pc,
    output logic            reg_write,
    output logic            alu_src,
    output logic [2:0]      alu_op,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem2reg,
    output logic [31:0]     ic,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [2:0]      dbgState
);

    localparam logic [31:0] MAX_COUNT = 32'(MAX_INS);
    localparam logic        LIMITED   = (MAX_INS != 0);

    state_t          state;
    ctl_word_t       decWord;
    logic            decIllegal;
    logic            pendRegWrite;
    logic            pendMemWrite;
    logic            isBranch;
    logic            isJump;
    logic [PC_W-1:0] nextPc;
    logic [31:0]     icNext;
    logic            haltNow;

    ctl_decode u_decode (
        .ins     (ins),
        .ctlWord (decWord),
        .illegal (decIllegal)
    );

    assign dbgState = state;
    assign icNext   = ic + 32'd1;
    assign haltNow  = LIMITED && (icNext == MAX_COUNT);

    // Offsets are in words; the sum wraps silently at PC_W bits.
    always_comb begin
        nextPc = pcp4;
        if (isJump) begin
            nextPc = pc + (jtarget << 2);
        end else if (isBranch && zero) begin
            nextPc = pc + (branch << 2);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pc           <= '0;
            ic           <= '0;
            pendRegWrite <= 1'b0;
            pendMemWrite <= 1'b0;
            isBranch     <= 1'b0;
            isJump       <= 1'b0;
            reg_write    <= 1'b0;
            alu_src      <= 1'b0;
            alu_op       <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem2reg      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_FETCH;
                        pc      <= entry_pc;
                        ic      <= '0;
                        illegal <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (decIllegal) begin
                        state   <= S_DONE;
                        illegal <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state        <= S_EXEC;
                        pendRegWrite <= decWord.regWrite;
                        pendMemWrite <= decWord.memWrite;
                        isBranch     <= decWord.isBranch;
                        isJump       <= decWord.isJump;
                        alu_src      <= decWord.aluSrc;
                        alu_op       <= decWord.aluOp;
                        mem_read     <= decWord.memRead;
                        mem2reg      <= decWord.mem2reg;
                    end
                end
                S_EXEC: begin
                    // Strobes are held back one cycle so they fire only in WRITE.
                    state     <= S_WRITE;
                    reg_write <= pendRegWrite;
                    mem_write <= pendMemWrite;
                end
                S_WRITE: begin
                    pc        <= nextPc;
                    ic        <= icNext;
                    reg_write <= 1'b0;
                    mem_write <= 1'b0;
                    alu_src   <= 1'b0;
                    alu_op    <= '0;
                    mem_read  <= 1'b0;
                    mem2reg   <= 1'b0;
                    if (haltNow) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
